// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite constants, FSM state type and lane helpers for the SRAM slave.
// Latency: n/a (pure types/functions).
// Backpressure: n/a.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY are answered with a plain OKAY.
  function automatic logic trans_active(input logic [1:0] trans);
    logic act;
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

  // Size above word, or a half/word not naturally aligned.
  function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = a[0];
      HSIZE_WORD: bad = (a != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane enables for a transfer; illegal sizes yield no lanes.
  function automatic logic [3:0] strobe_gen(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << a;
      HSIZE_HALF: strb = 4'b0011 << {a[1], 1'b0};
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Per-lane select: lanes set in sel come from fwd, the rest from ram.
  function automatic logic [31:0] lane_merge(input logic [31:0] ram, input logic [31:0] fwd,
                                             input logic [3:0] sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? fwd[8*i +: 8] : ram[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_bytewe.sv
// Word-wide synchronous RAM, 4 byte write enables, registered read output.
// Latency: read data one cycle after re; write lands on the clock edge.
// Backpressure: none; separate read/write addresses so a commit and a new read can share a cycle.
// Ports: clk; waddr/we/wdata write side; re/raddr/rdata read side (rdata holds when re=0).
module sram_bytewe #(
  parameter int    AW        = 17,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Read-during-write to the same word returns the old contents; the slave forwards around it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writable memory with wait states, error responses, write->read forwarding.
// Latency: OKAY data phase lasts WAIT_STATES+1 cycles; ERROR is always 2 cycles.
// Backpressure: hreadyout low during waits and ERR1; no address accepted while hready is low.
// Ports: sys_clk/sys_resetn; AHB address phase hsel/haddr/htrans/hsize/hwrite/hready;
//        data phase hwdata in, hreadyout/hresp/hrdata out.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int    AWIDTH      = 19,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata
);

  localparam int WW = AWIDTH - 2;

  state_t        state, state_nxt;
  logic [2:0]    wcnt, wcnt_nxt;
  logic [WW-1:0] addr_q;
  logic [3:0]    strb_q;
  logic          wr_q;
  logic          legal_q;
  logic          fwd_hit;
  logic [31:0]   fwd_dat;
  logic [3:0]    fwd_strb;

  logic          accept;
  logic          illegal;
  logic          commit;
  logic          fwd_now;
  logic [3:0]    ram_we;
  logic [31:0]   ram_q;

  assign accept  = hsel & trans_active(htrans) & hready;
  assign illegal = xfer_illegal(hsize, haddr[1:0]);

  // Write lands on the last data-phase cycle, using live hwdata.
  assign commit  = (state == ST_DATA) && (wcnt == 3'd0) && wr_q && legal_q;
  assign ram_we  = commit ? strb_q : 4'b0000;

  // A read accepted on the same edge the RAM takes a write to that word would see stale bytes.
  assign fwd_now = accept && !hwrite && !illegal && commit && (haddr[AWIDTH-1:2] == addr_q);

  sram_bytewe #(
    .AW        (WW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (sys_clk),
    .waddr (addr_q),
    .we    (ram_we),
    .wdata (hwdata),
    .re    (accept & ~hwrite),
    .raddr (haddr[AWIDTH-1:2]),
    .rdata (ram_q)
  );

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = illegal ? ST_ERR1 : ST_DATA;
          wcnt_nxt  = illegal ? 3'd0 : 3'(WAIT_STATES);
        end
      end
      ST_DATA: begin
        if (wcnt != 3'd0) begin
          hreadyout = 1'b0;
          wcnt_nxt  = wcnt - 3'd1;
        end else if (accept) begin
          state_nxt = illegal ? ST_ERR1 : ST_DATA;
          wcnt_nxt  = illegal ? 3'd0 : 3'(WAIT_STATES);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hresp = 1'b1;
        if (accept) begin
          state_nxt = illegal ? ST_ERR1 : ST_DATA;
          wcnt_nxt  = illegal ? 3'd0 : 3'(WAIT_STATES);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Driven only in a legal read data phase; the RAM output is held since accept, so it is stable across waits.
  assign hrdata = (state == ST_DATA && !wr_q) ?
                  lane_merge(ram_q, fwd_dat, fwd_hit ? fwd_strb : 4'b0000) : 32'h0;

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state    <= ST_IDLE;
      wcnt     <= 3'd0;
      addr_q   <= '0;
      strb_q   <= 4'b0000;
      wr_q     <= 1'b0;
      legal_q  <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_dat  <= 32'h0;
      fwd_strb <= 4'b0000;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept) begin
        addr_q  <= haddr[AWIDTH-1:2];
        strb_q  <= strobe_gen(hsize, haddr[1:0]);
        wr_q    <= hwrite;
        legal_q <= ~illegal;
        fwd_hit <= fwd_now;
        if (fwd_now) begin
          fwd_dat  <= hwdata;
          fwd_strb <= strb_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
module tb_ahb_sram_slave;
  import ahb_sram_pkg::*;

  localparam int AW = 12;

  typedef struct {
    logic          wr;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } xfer_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [31:0]   hwdata;
  logic          sel;
  logic          ro0, rs0, ro3, rs3;
  logic [31:0]   rd0, rd3;
  logic          ro, rs;
  logic [31:0]   rd;

  int checks = 0;
  int passed = 0;

  logic [7:0] mm [int];
  xfer_t      xq [$];
  exp_t       sb [$];

  always #5 clk = ~clk;

  assign ro = sel ? ro3 : ro0;
  assign rs = sel ? rs3 : rs0;
  assign rd = sel ? rd3 : rd0;

  ahb_sram_slave #(.AWIDTH(AW), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .sys_clk(clk), .sys_resetn(rst_n), .hsel(hsel & ~sel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(ro0),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

  ahb_sram_slave #(.AWIDTH(AW), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
    .sys_clk(clk), .sys_resetn(rst_n), .hsel(hsel & sel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(ro3),
    .hreadyout(ro3), .hresp(rs3), .hrdata(rd3));

  // ---------------- reference model (byte-addressed, one image per DUT) ----------------
  function automatic int mkey(input int a);
    return (sel ? 65536 : 0) + a;
  endfunction

  function automatic bit m_illegal(input xfer_t x);
    if (x.size > 3'd2) return 1'b1;
    return (int'(x.addr) % (1 << x.size)) != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    logic [31:0] v;
    int base;
    base = int'(a) - (int'(a) % 4);
    for (int i = 0; i < 4; i++) begin
      v[8*i +: 8] = mm.exists(mkey(base + i)) ? mm[mkey(base + i)] : 8'h00;
    end
    return v;
  endfunction

  task automatic m_write(input xfer_t x);
    int a;
    for (int k = 0; k < (1 << x.size); k++) begin
      a = int'(x.addr) + k;
      mm[mkey(a)] = x.data[8*(a % 4) +: 8];
    end
  endtask

  function automatic void add(input logic wr, input logic [2:0] size, input logic [AW-1:0] addr,
                              input logic [31:0] data);
    xfer_t x;
    x.wr = wr; x.size = size; x.addr = addr; x.data = data;
    xq.push_back(x);
  endfunction

  // Pipelined AHB master: issues xq back to back, scoreboard push on accept, pop on completion.
  task automatic run_xfers(input string tag);
    xfer_t cur, nxt;
    exp_t  e;
    bit    have_cur, have_nxt, acc;
    int    waits, guard;
    logic  o_ro, o_rs;
    logic [31:0] o_rd;
    have_cur = 1'b0;
    waits    = 0;
    guard    = 0;
    cur      = '{1'b0, 3'd0, '0, 32'h0};
    while ((xq.size() != 0 || have_cur) && guard < 200) begin
      guard++;
      have_nxt = (xq.size() != 0);
      if (have_nxt) begin
        nxt    = xq[0];
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = nxt.addr;
        hsize  = nxt.size;
        hwrite = nxt.wr;
      end else begin
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
      end
      hwdata = (have_cur && cur.wr) ? cur.data : 32'h0;
      @(negedge clk);
      o_ro = ro; o_rs = rs; o_rd = rd;
      if (have_cur) begin
        e = sb[0];
        checks++;
        if (o_rs !== e.err)
          $display("FAIL %s hresp addr=%0h: got %b want %b", tag, cur.addr, o_rs, e.err);
        else passed++;
        if (o_ro) begin
          checks++;
          if (waits != e.waits)
            $display("FAIL %s wait_cycles addr=%0h: got %0d want %0d", tag, cur.addr, waits, e.waits);
          else passed++;
          checks++;
          if (o_rd !== e.rdata)
            $display("FAIL %s hrdata addr=%0h: got %h want %h", tag, cur.addr, o_rd, e.rdata);
          else passed++;
          if (!e.err && cur.wr) m_write(cur);
          e = sb.pop_front();
          have_cur = 1'b0;
        end else begin
          waits++;
        end
      end
      acc = have_nxt && o_ro;
      @(posedge clk); #1;
      if (acc) begin
        nxt     = xq.pop_front();
        e.err   = m_illegal(nxt);
        e.rdata = (!nxt.wr && !e.err) ? m_read(nxt.addr) : 32'h0;
        e.waits = e.err ? 1 : (sel ? 3 : 0);
        sb.push_back(e);
        cur      = nxt;
        have_cur = 1'b1;
        waits    = 0;
      end
    end
    if (guard >= 200) begin
      checks++;
      $display("FAIL %s timeout: got %0d cycles want <200", tag, guard);
      xq.delete();
      sb.delete();
    end
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = 32'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (ro0 !== 1'b1) $display("FAIL reset hreadyout0: got %b want 1", ro0); else passed++;
    checks++; if (rs0 !== 1'b0) $display("FAIL reset hresp0: got %b want 0", rs0); else passed++;
    checks++; if (rd0 !== 32'h0) $display("FAIL reset hrdata0: got %h want 0", rd0); else passed++;
    checks++; if (ro3 !== 1'b1) $display("FAIL reset hreadyout3: got %b want 1", ro3); else passed++;
    checks++; if (rs3 !== 1'b0) $display("FAIL reset hresp3: got %b want 0", rs3); else passed++;
    checks++; if (rd3 !== 32'h0) $display("FAIL reset hrdata3: got %h want 0", rd3); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_rw();
    sel = 1'b0;
    add(1'b1, HSIZE_WORD, 12'h100, 32'hDEADBEEF);
    run_xfers("basic_wr");
    add(1'b0, HSIZE_WORD, 12'h100, 32'h0);
    run_xfers("basic_rd");
    @(negedge clk);
    checks++;
    if (rd0 !== 32'h0) $display("FAIL idle_hrdata: got %h want 0", rd0); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_lanes();
    sel = 1'b0;
    add(1'b1, HSIZE_BYTE, 12'h200, 32'h00000011);
    add(1'b1, HSIZE_BYTE, 12'h201, 32'h00002200);
    add(1'b1, HSIZE_BYTE, 12'h202, 32'h00330000);
    add(1'b1, HSIZE_BYTE, 12'h203, 32'h44000000);
    add(1'b0, HSIZE_WORD, 12'h200, 32'h0);
    add(1'b1, HSIZE_HALF, 12'h202, 32'hAAAA0000);
    add(1'b0, HSIZE_WORD, 12'h200, 32'h0);
    add(1'b0, HSIZE_BYTE, 12'h201, 32'h0);
    run_xfers("byte_lanes");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    add(1'b1, HSIZE_WORD, 12'h040, 32'h0BADF00D);
    run_xfers("b2b_init");
    add(1'b1, HSIZE_WORD, 12'h040, 32'h12345678);
    add(1'b0, HSIZE_WORD, 12'h040, 32'h0);
    run_xfers("b2b_fwd");
  endtask

  task automatic test_errors();
    sel = 1'b0;
    add(1'b1, HSIZE_WORD, 12'h041, 32'hFFFFFFFF);
    add(1'b0, HSIZE_HALF, 12'h003, 32'h0);
    add(1'b0, 3'd3,       12'h044, 32'h0);
    add(1'b0, HSIZE_WORD, 12'h040, 32'h0);
    run_xfers("errors");
  endtask

  task automatic test_wait_states();
    sel = 1'b1;
    add(1'b1, HSIZE_WORD, 12'h010, 32'hA5A55A5A);
    add(1'b0, HSIZE_WORD, 12'h010, 32'h0);
    add(1'b0, HSIZE_WORD, 12'h010, 32'h0);
    add(1'b1, HSIZE_BYTE, 12'h013, 32'h77000000);
    add(1'b0, HSIZE_WORD, 12'h010, 32'h0);
    add(1'b0, HSIZE_WORD, 12'h012, 32'h0);
    add(1'b0, HSIZE_WORD, 12'h010, 32'h0);
    run_xfers("wait_states");
  endtask

  task automatic test_reset_mid_wait();
    sel = 1'b1;
    add(1'b1, HSIZE_WORD, 12'h080, 32'hCAFEF00D);
    run_xfers("rst_init");
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = 12'h080;
    hsize  = HSIZE_WORD;
    hwrite = 1'b1;
    @(posedge clk); #1;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = 32'h0BADBEEF;
    @(posedge clk); #1;
    checks++;
    if (ro3 !== 1'b0) $display("FAIL rst_midwait_pre hreadyout: got %b want 0", ro3); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (ro3 !== 1'b1) $display("FAIL rst_async hreadyout: got %b want 1", ro3); else passed++;
    checks++; if (rs3 !== 1'b0) $display("FAIL rst_async hresp: got %b want 0", rs3); else passed++;
    checks++; if (rd3 !== 32'h0) $display("FAIL rst_async hrdata: got %h want 0", rd3); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    hwdata = 32'h0;
    @(posedge clk); #1;
    sb.delete();
    add(1'b0, HSIZE_WORD, 12'h080, 32'h0);
    run_xfers("rst_readback");
  endtask

  initial begin
    sel    = 1'b0;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = HTRANS_IDLE;
    hsize  = HSIZE_WORD;
    hwrite = 1'b0;
    hwdata = 32'h0;
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_wait_states();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
